mesi_bus_ctrl_rr: RTL and testbench

Parametrised MESI snooping bus controller sitting between `CPUS` private L1 data caches and the shared L2. It serialises coherence transactions (read, read-exclusive, upgrade, writeback) with round-robin arbitration over any CPU count. It broadcasts snoops and performs cache-to-cache transfers through an internal line buffer, writing dirty supplied lines back to L2. Block size is configurable in 64-bit beats.

---
 rtl/mesi_bus_ctrl_rr_if.sv | 51 +++++
 rtl/mesi_bus_ctrl_rr.sv | 227 ++++++++++++++++++++++
 tb/tb_mesi_bus_ctrl_rr.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesi_bus_ctrl_rr_if.sv
// Bus bundle between the MESI controller and its caches / L2.
// master: the controller. slave: the caches plus L2 side.
interface mesi_bus_ctrl_rr_if #(
    parameter int CPUS   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    // requests from the L1s
    logic [CPUS-1:0]             req_valid;
    logic [CPUS-1:0][1:0]        req_op;
    logic [CPUS-1:0][ADDR_W-1:0] req_addr;
    logic [CPUS-1:0][DATA_W-1:0] req_wdata;
    // responses to the requester
    logic [CPUS-1:0]             rsp_ready;
    logic [DATA_W-1:0]           rsp_rdata;
    logic [CPUS-1:0]             rsp_exclusive;
    // snoop broadcast and replies
    logic                        snoop_valid;
    logic                        snoop_inv;
    logic [ADDR_W-1:0]           snoop_addr;
    logic [CPUS-1:0]             snoop_mask;
    logic [CPUS-1:0]             snoop_hit;
    logic [CPUS-1:0]             snoop_dirty;
    logic [CPUS-1:0][DATA_W-1:0] snoop_data;
    logic [CPUS-1:0]             snoop_data_valid;
    // shared L2 port
    logic                        l2_ren;
    logic                        l2_wen;
    logic [ADDR_W-1:0]           l2_addr;
    logic [DATA_W-1:0]           l2_wdata;
    logic [DATA_W-1:0]           l2_rdata;
    logic                        l2_ready;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata,
        output rsp_ready, rsp_rdata, rsp_exclusive,
        output snoop_valid, snoop_inv, snoop_addr, snoop_mask,
        input  snoop_hit, snoop_dirty, snoop_data, snoop_data_valid,
        output l2_ren, l2_wen, l2_addr, l2_wdata,
        input  l2_rdata, l2_ready
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata,
        input  rsp_ready, rsp_rdata, rsp_exclusive,
        input  snoop_valid, snoop_inv, snoop_addr, snoop_mask,
        output snoop_hit, snoop_dirty, snoop_data, snoop_data_valid,
        input  l2_ren, l2_wen, l2_addr, l2_wdata,
        output l2_rdata, l2_ready
    );
endinterface

// File: rtl/mesi_bus_ctrl_rr.sv
// MESI snooping bus controller: round-robin grant, one transaction in flight,
// cache-to-cache fills through a line buffer, dirty supplied lines written to L2.
module mesi_bus_ctrl_rr #(
    parameter int CPUS        = 4,
    parameter int BLOCK_WORDS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64
) (
    input logic                CLK,
    input logic                nRST,
    mesi_bus_ctrl_rr_if.master bus
);
    localparam int CW = $clog2(CPUS);
    localparam int BW = $clog2(BLOCK_WORDS) + 1;
    localparam int IW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    typedef enum logic [1:0] {OP_RD, OP_RDX, OP_UPGR, OP_WB} op_e;
    typedef enum logic [2:0] {IDLE, SNOOP, XFER, RMEM, WMEM, WB_BUF, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     rr_ptr_q, rr_ptr_d, req_q, req_d, sup_q, sup_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              dirty_q, dirty_d;
    logic [DATA_W-1:0] line_q [BLOCK_WORDS];
    logic [DATA_W-1:0] line_d [BLOCK_WORDS];

    logic              gnt_found, sup_found;
    logic [CW-1:0]     gnt_idx, sup_idx, cand;
    logic [CPUS-1:0]   mask_req, hits;
    logic [IW-1:0]     beat_idx;
    logic [ADDR_W-1:0] beat_addr;
    logic [CW-1:0]     next_ptr;
    logic              last_beat;

    logic [CPUS-1:0]   rsp_ready, rsp_excl;
    logic [DATA_W-1:0] rsp_rdata, l2_wdata;
    logic [ADDR_W-1:0] snoop_addr, l2_addr;
    logic [CPUS-1:0]   snoop_mask;
    logic              snoop_valid, snoop_inv, l2_ren, l2_wen;

    assign mask_req  = ~(CPUS'(1) << req_q);
    assign hits      = bus.snoop_hit & mask_req;
    assign beat_idx  = IW'(beat_q);
    // base is line aligned, so OR-ing the beat offset never leaves the line
    assign beat_addr = base_q | (ADDR_W'(beat_idx) << 3);
    assign next_ptr  = (req_q == CW'(CPUS - 1)) ? '0 : req_q + CW'(1);
    assign last_beat = (beat_q == BW'(BLOCK_WORDS - 1));

    // round-robin pick: scan downward so the lowest offset from rr_ptr wins
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            cand = CW'((int'(rr_ptr_q) + i) % CPUS);
            if (bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // supplier is the lowest-index hit among the snooped caches
    always_comb begin
        sup_found = 1'b0;
        sup_idx   = '0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            if (hits[CW'(i)]) begin
                sup_found = 1'b1;
                sup_idx   = CW'(i);
            end
        end
    end

    // next-state and output decode
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        req_d       = req_q;
        op_d        = op_q;
        base_d      = base_q;
        beat_d      = beat_q;
        dirty_d     = dirty_q;
        sup_d       = sup_q;
        line_d      = line_q;
        rsp_ready   = '0;
        rsp_excl    = '0;
        rsp_rdata   = '0;
        snoop_valid = 1'b0;
        snoop_inv   = 1'b0;
        snoop_addr  = '0;
        snoop_mask  = '0;
        l2_ren      = 1'b0;
        l2_wen      = 1'b0;
        l2_addr     = '0;
        l2_wdata    = '0;
        case (state_q)
            IDLE: if (gnt_found) begin
                req_d   = gnt_idx;
                op_d    = op_e'(bus.req_op[gnt_idx]);
                base_d  = bus.req_addr[gnt_idx] & ~ADDR_W'(BLOCK_WORDS * 8 - 1);
                beat_d  = '0;
                state_d = (op_e'(bus.req_op[gnt_idx]) == OP_WB) ? WMEM : SNOOP;
            end
            SNOOP: begin
                snoop_valid = 1'b1;
                snoop_inv   = (op_q == OP_RDX) || (op_q == OP_UPGR);
                snoop_addr  = base_q;
                snoop_mask  = mask_req;
                beat_d      = '0;
                if (op_q == OP_UPGR) begin
                    state_d = DONE;
                end else if (sup_found) begin
                    sup_d   = sup_idx;
                    dirty_d = bus.snoop_dirty[sup_idx];
                    state_d = XFER;
                end else begin
                    state_d = RMEM;
                end
            end
            XFER: if (bus.snoop_data_valid[sup_q]) begin
                rsp_ready[req_q]   = 1'b1;
                rsp_excl[req_q]    = (op_q == OP_RDX);
                rsp_rdata          = bus.snoop_data[sup_q];
                line_d[beat_idx]   = bus.snoop_data[sup_q];
                beat_d             = beat_q + BW'(1);
                if (last_beat) begin
                    if (op_q == OP_RD && dirty_q) begin
                        beat_d  = '0;
                        state_d = WB_BUF;
                    end else begin
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end
                end
            end
            RMEM: begin
                l2_ren  = 1'b1;
                l2_addr = beat_addr;
                if (bus.l2_ready) begin
                    rsp_ready[req_q] = 1'b1;
                    rsp_excl[req_q]  = 1'b1;
                    rsp_rdata        = bus.l2_rdata;
                    beat_d           = beat_q + BW'(1);
                    if (last_beat) begin
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end
                end
            end
            WMEM: begin
                l2_wen   = 1'b1;
                l2_addr  = beat_addr;
                l2_wdata = bus.req_wdata[req_q];
                if (bus.l2_ready) begin
                    rsp_ready[req_q] = 1'b1;
                    beat_d           = beat_q + BW'(1);
                    if (last_beat) begin
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end
                end
            end
            WB_BUF: begin
                l2_wen   = 1'b1;
                l2_addr  = beat_addr;
                l2_wdata = line_q[beat_idx];
                if (bus.l2_ready) begin
                    beat_d = beat_q + BW'(1);
                    if (last_beat) begin
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end
                end
            end
            DONE: begin
                rsp_ready[req_q] = 1'b1;
                rsp_excl[req_q]  = 1'b1;
                rr_ptr_d         = next_ptr;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // control state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            req_q    <= '0;
            op_q     <= OP_RD;
            base_q   <= '0;
            beat_q   <= '0;
            dirty_q  <= 1'b0;
            sup_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            req_q    <= req_d;
            op_q     <= op_d;
            base_q   <= base_d;
            beat_q   <= beat_d;
            dirty_q  <= dirty_d;
            sup_q    <= sup_d;
        end
    end

    // line buffer holds no control meaning, so it needs no reset
    always_ff @(posedge CLK) begin
        line_q <= line_d;
    end

    assign bus.rsp_ready     = rsp_ready;
    assign bus.rsp_exclusive = rsp_excl;
    assign bus.rsp_rdata     = rsp_rdata;
    assign bus.snoop_valid   = snoop_valid;
    assign bus.snoop_inv     = snoop_inv;
    assign bus.snoop_addr    = snoop_addr;
    assign bus.snoop_mask    = snoop_mask;
    assign bus.l2_ren        = l2_ren;
    assign bus.l2_wen        = l2_wen;
    assign bus.l2_addr       = l2_addr;
    assign bus.l2_wdata      = l2_wdata;
endmodule

// File: tb/tb_mesi_bus_ctrl_rr.sv
// Directed bench for mesi_bus_ctrl_rr: miss, dirty hit, RDX hit, upgrade,
// round-robin fairness, stall and asynchronous reset.
module tb_mesi_bus_ctrl_rr;
    localparam int CPUS = 4, BLOCK_WORDS = 2, ADDR_W = 32, DATA_W = 64;
    localparam logic [1:0] RD = 2'b00, RDX = 2'b01, UPGR = 2'b10, WB = 2'b11;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   order [5] = '{0, 1, 2, 3, 0};

    mesi_bus_ctrl_rr_if #(.CPUS(CPUS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mesi_bus_ctrl_rr #(
        .CPUS(CPUS), .BLOCK_WORDS(BLOCK_WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.req_valid        = '0;
        bus.req_op           = '0;
        bus.req_addr         = '0;
        bus.req_wdata        = '0;
        bus.snoop_hit        = '0;
        bus.snoop_dirty      = '0;
        bus.snoop_data       = '0;
        bus.snoop_data_valid = '0;
        bus.l2_rdata         = '0;
        bus.l2_ready         = 1'b0;
    endtask

    task automatic set_req(input int cpu, input logic [1:0] op, input logic [31:0] addr);
        bus.req_valid[cpu] = 1'b1;
        bus.req_op[cpu]    = op;
        bus.req_addr[cpu]  = addr;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".rsp_ready"},   64'(bus.rsp_ready), 64'h0);
        check({tag, ".rsp_rdata"},   bus.rsp_rdata, 64'h0);
        check({tag, ".rsp_excl"},    64'(bus.rsp_exclusive), 64'h0);
        check({tag, ".snoop_valid"}, 64'(bus.snoop_valid), 64'h0);
        check({tag, ".snoop_inv"},   64'(bus.snoop_inv), 64'h0);
        check({tag, ".snoop_addr"},  64'(bus.snoop_addr), 64'h0);
        check({tag, ".snoop_mask"},  64'(bus.snoop_mask), 64'h0);
        check({tag, ".l2_ren"},      64'(bus.l2_ren), 64'h0);
        check({tag, ".l2_wen"},      64'(bus.l2_wen), 64'h0);
        check({tag, ".l2_addr"},     64'(bus.l2_addr), 64'h0);
        check({tag, ".l2_wdata"},    bus.l2_wdata, 64'h0);
    endtask

    initial begin
        // reset state
        clear_in();
        #12;
        check_zero("reset");
        tick();
        nRST = 1'b1;

        // RD miss: CPU2 0x1004, L2 returns A,B back to back
        tick();
        set_req(2, RD, 32'h1004);
        #2;
        check_zero("t1_grant");
        tick(); #2;
        check("t1_snoop_valid", 64'(bus.snoop_valid), 64'h1);
        check("t1_snoop_addr",  64'(bus.snoop_addr), 64'h1000);
        check("t1_snoop_mask",  64'(bus.snoop_mask), 64'hB);
        check("t1_snoop_inv",   64'(bus.snoop_inv), 64'h0);
        tick();
        bus.l2_ready = 1'b1;
        bus.l2_rdata = 64'hA;
        #2;
        check("t1_ren0",   64'(bus.l2_ren), 64'h1);
        check("t1_addr0",  64'(bus.l2_addr), 64'h1000);
        check("t1_rdy0",   64'(bus.rsp_ready), 64'h4);
        check("t1_data0",  bus.rsp_rdata, 64'hA);
        check("t1_excl0",  64'(bus.rsp_exclusive), 64'h4);
        tick();
        bus.l2_rdata = 64'hB;
        #2;
        check("t1_addr1",  64'(bus.l2_addr), 64'h1008);
        check("t1_rdy1",   64'(bus.rsp_ready), 64'h4);
        check("t1_data1",  bus.rsp_rdata, 64'hB);
        tick();
        clear_in();
        #2;
        check_zero("t1_idle");

        // RD hit dirty: CPU0 0x2000, CPU3 supplies C,D; own hit from CPU0 ignored
        set_req(0, RD, 32'h2000);
        tick();
        bus.snoop_hit   = 4'b1001;
        bus.snoop_dirty = 4'b1001;
        #2;
        check("t2_snoop_mask", 64'(bus.snoop_mask), 64'hE);
        check("t2_snoop_addr", 64'(bus.snoop_addr), 64'h2000);
        check("t2_snoop_inv",  64'(bus.snoop_inv), 64'h0);
        tick();
        bus.snoop_hit   = '0;
        bus.snoop_dirty = '0;
        #2;
        check("t2_stall_rdy", 64'(bus.rsp_ready), 64'h0);
        tick();
        bus.snoop_data_valid = 4'b0010;
        bus.snoop_data[1]    = 64'hBAD;
        #2;
        check("t2_nonsup_rdy", 64'(bus.rsp_ready), 64'h0);
        tick();
        bus.snoop_data_valid = 4'b1000;
        bus.snoop_data[1]    = 64'h0;
        bus.snoop_data[3]    = 64'hC;
        #2;
        check("t2_rdy0",  64'(bus.rsp_ready), 64'h1);
        check("t2_data0", bus.rsp_rdata, 64'hC);
        check("t2_excl0", 64'(bus.rsp_exclusive), 64'h0);
        tick();
        bus.snoop_data[3] = 64'hD;
        #2;
        check("t2_rdy1",  64'(bus.rsp_ready), 64'h1);
        check("t2_data1", bus.rsp_rdata, 64'hD);
        tick();
        clear_in();
        bus.l2_ready = 1'b1;
        #2;
        check("t2_wb_wen0",  64'(bus.l2_wen), 64'h1);
        check("t2_wb_addr0", 64'(bus.l2_addr), 64'h2000);
        check("t2_wb_data0", bus.l2_wdata, 64'hC);
        check("t2_wb_rdy0",  64'(bus.rsp_ready), 64'h0);
        tick(); #2;
        check("t2_wb_wen1",  64'(bus.l2_wen), 64'h1);
        check("t2_wb_addr1", 64'(bus.l2_addr), 64'h2008);
        check("t2_wb_data1", bus.l2_wdata, 64'hD);
        tick();
        clear_in();
        #2;
        check_zero("t2_idle");

        // RDX hit: CPU1 0x3000, CPU0 and CPU2 hit, CPU0 supplies
        set_req(1, RDX, 32'h3000);
        tick();
        bus.snoop_hit   = 4'b0101;
        bus.snoop_dirty = 4'b0100;
        #2;
        check("t3_snoop_inv",  64'(bus.snoop_inv), 64'h1);
        check("t3_snoop_mask", 64'(bus.snoop_mask), 64'hD);
        tick();
        bus.snoop_hit        = '0;
        bus.snoop_dirty      = '0;
        bus.snoop_data_valid = 4'b0101;
        bus.snoop_data[0]    = 64'hE0;
        bus.snoop_data[2]    = 64'hBAD2;
        #2;
        check("t3_rdy0",  64'(bus.rsp_ready), 64'h2);
        check("t3_data0", bus.rsp_rdata, 64'hE0);
        check("t3_excl0", 64'(bus.rsp_exclusive), 64'h2);
        tick();
        bus.snoop_data[0] = 64'hE1;
        #2;
        check("t3_rdy1",  64'(bus.rsp_ready), 64'h2);
        check("t3_data1", bus.rsp_rdata, 64'hE1);
        tick();
        clear_in();
        #2;
        check_zero("t3_no_l2");

        // UPGR: CPU1 0x4000, grant / snoop / done
        set_req(1, UPGR, 32'h4000);
        tick(); #2;
        check("t4_snoop_valid", 64'(bus.snoop_valid), 64'h1);
        check("t4_snoop_inv",   64'(bus.snoop_inv), 64'h1);
        check("t4_snoop_addr",  64'(bus.snoop_addr), 64'h4000);
        check("t4_rdy_early",   64'(bus.rsp_ready), 64'h0);
        tick(); #2;
        check("t4_rdy",  64'(bus.rsp_ready), 64'h2);
        check("t4_excl", 64'(bus.rsp_exclusive), 64'h2);
        check("t4_ren",  64'(bus.l2_ren), 64'h0);
        check("t4_wen",  64'(bus.l2_wen), 64'h0);
        tick();
        clear_in();
        #2;
        check_zero("t4_idle");

        // fairness: all four hold WB from reset
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        for (int i = 0; i < CPUS; i++) begin
            set_req(i, WB, 32'h5000 + 32'(i) * 32'h100);
            bus.req_wdata[i] = 64'hD0 + 64'(i);
        end
        bus.l2_ready = 1'b1;
        #2;
        check("t5_idle0", 64'(bus.l2_wen), 64'h0);
        for (int k = 0; k < 5; k++) begin
            tick(); #2;
            check("t5_wen0",  64'(bus.l2_wen), 64'h1);
            check("t5_gnt0",  64'(bus.rsp_ready), 64'(4'b0001 << order[k]));
            check("t5_addr0", 64'(bus.l2_addr), 64'h5000 + 64'(order[k]) * 64'h100);
            check("t5_data0", bus.l2_wdata, 64'hD0 + 64'(order[k]));
            tick(); #2;
            check("t5_wen1",  64'(bus.l2_wen), 64'h1);
            check("t5_gnt1",  64'(bus.rsp_ready), 64'(4'b0001 << order[k]));
            check("t5_addr1", 64'(bus.l2_addr), 64'h5008 + 64'(order[k]) * 64'h100);
            tick();
            if (k == 4) clear_in();
            #2;
            check("t5_idle", 64'(bus.l2_wen), 64'h0);
        end

        // stall in RMEM for 5 cycles, then asynchronous reset
        set_req(3, RD, 32'h6010);
        tick(); #2;
        check("t6_snoop_mask", 64'(bus.snoop_mask), 64'h7);
        tick();
        for (int c = 0; c < 5; c++) begin
            #2;
            check("t6_stall_ren",  64'(bus.l2_ren), 64'h1);
            check("t6_stall_addr", 64'(bus.l2_addr), 64'h6010);
            check("t6_stall_rdy",  64'(bus.rsp_ready), 64'h0);
            tick();
        end
        nRST = 1'b0;
        #1;
        check_zero("t6_reset");
        tick();
        nRST = 1'b1;
        clear_in();
        set_req(1, RD, 32'h7000);
        set_req(3, RD, 32'h6010);
        #2;
        check_zero("t6_idle");
        tick(); #2;
        check("t6_regrant_mask", 64'(bus.snoop_mask), 64'hD);
        check("t6_regrant_addr", 64'(bus.snoop_addr), 64'h7000);
        clear_in();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
